fp_norm_round: RTL and testbench
================================

Name: fp_norm_round

Overview:
Post-add normalizer and rounder for the fp32 adder. It is the inverse stage of the 24-bit alignment right shifter.
- Consumes the raw 28-bit significand sum, with carry and guard/round/sticky (GRS) bits.
- Left- or right-normalizes it, rounds to nearest-even and packs an IEEE-754 single.
- Two-stage pipeline with valid/ready handshake, between the significand adder and the result register.

Parameters:
EXP_W, 8, exponent field width
FRAC_W, 23, stored fraction width (hidden bit excluded)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  input beat present
in_ready  output  1  block accepts beat this cycle
in_sign  input  1  sign of the sum
in_exp  input  8  biased exponent of the larger operand, pre-normalization
in_man  input  28  bit27 = carry, bits26:3 = significand (hidden bit at 26), bit2 = G, bit1 = R, bit0 = S
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_result  output  32  packed fp32 {sign, exp, frac}

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset values: out_valid = 0, out_result = 0, internal valids = 0.
- in_ready is combinational and is 1 while idle after reset.
- Reset mid-operation discards all in-flight beats. No partial output.

Handshake:
- s2_adv = ~v2 | out_ready
- s1_adv = ~v1 | s2_adv
- in_ready = s1_adv
- A beat transfers when valid & ready.
- Latency is 2 cycles from accept to out_valid with no stall. Throughput is 1 per cycle.
- out_result and out_valid hold stable while out_valid & ~out_ready.
- Order is preserved. No bubbles are inserted when out_ready stays high.

Stage 1 (normalize):
- Internal exponent is 10-bit signed, zero-extended from in_exp.
- If in_man == 0: set the zero flag; result is +0 regardless of sign.
- Else if bit27 == 1: shift right by 1, new S = old S | old bit0, exp += 1.
- Else: lz = leading zeros of bits26:0 (0..26).
  - Shift left by lz with zero fill. GRS shift as ordinary bits.
  - exp -= lz.
- Register the normalized 27-bit value, exp, sign and the zero flag into v1.

Stage 2 (round and pack):
- L = bit3, G = bit2, R = bit1, S = bit0.
- round_up = G & (R | S | L).
- frac24 = bits26:3 + round_up.
- If the increment carries out of 24 bits: frac24 = 0x800000, exp += 1.

Exceptions, in priority order:
1. zero flag → 0x00000000.
2. exp <= 0 → flush-to-zero: {sign, 31'b0}. No subnormal output.
3. exp >= 255 → {sign, 8'hFF, 23'b0} (infinity).
4. Otherwise → {sign, exp[7:0], frac24[22:0]}.

Input range: inputs with in_exp == 255 (inf/NaN) are out of scope and are handled by the upstream special-case path. This block's output for them is unspecified.

Decomposition:
- Shared package fp_pkg holds:
  - EXP_BIAS = 127
  - EXP_MAX = 255
  - FRAC_W = 23
  - GRS_W = 3
  - MAN_SUM_W = 28
  - fp32 field slice constants
- One sub-module: man_lzc.
  - Combinational 27-bit leading-zero counter with 5-bit count output and all-zero flag.
  - Used in stage 1.

Test Plan:
1. Carry normalize: sign = 0, in_exp = 127, in_man = 28'h8000000 → out_result = 0x40000000, two cycles after accept.
2. Massive cancellation: in_exp = 127, in_man = 28'h0000008 → lz = 23 → 0x34000000. Also in_man = 0 with sign = 1 → 0x00000000.
3. Round-to-nearest-even:
   - in_exp = 127, in_man = 28'h4000004 (tie, L = 0) → 0x3F800000.
   - in_man = 28'h400000C (tie, L = 1) → 0x3F800002.
   - in_man = 28'h7FFFFFC (all ones, G = 1) → round carry → 0x40000000.
4. Overflow and underflow:
   - in_exp = 254, in_man = 28'h8000000, sign = 1 → 0xFF800000.
   - in_exp = 3, in_man = 28'h0000008 → 0x00000000.
5. Backpressure: stream 4 beats with out_ready = 0 for 3 cycles.
   - Two beats are accepted, then in_ready = 0.
   - out_result is held stable.
   - After out_ready = 1, all 4 results emerge in order, one per cycle.
6. Reset mid-stream: assert rst with both stages valid.
   - out_valid drops asynchronously. out_result = 0.
   - After release, the first new beat appears at latency 2 with no stale output.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared fp32 constants and the stage-1 payload type for the post-add normalizer/rounder.
package fp_pkg;

    localparam int unsigned EXP_BIAS    = 127;
    localparam int unsigned EXP_MAX     = 255;
    localparam int unsigned FRAC_W      = 23;
    localparam int unsigned GRS_W       = 3;
    localparam int unsigned MAN_SUM_W   = 28;

    localparam int unsigned NORM_W      = MAN_SUM_W - 1;   // significand + GRS, carry removed
    localparam int unsigned SIG_W       = NORM_W - GRS_W;  // hidden bit + fraction
    localparam int unsigned LZC_W       = 5;
    localparam int unsigned EXP_INT_W   = 10;              // signed working exponent

    localparam int unsigned FP_W        = 32;
    localparam int unsigned FP_SIGN_BIT = 31;
    localparam int unsigned FP_EXP_MSB  = 30;
    localparam int unsigned FP_EXP_LSB  = 23;
    localparam int unsigned FP_FRAC_MSB = 22;

    typedef struct packed {
        logic                        sign;
        logic                        zero;
        logic signed [EXP_INT_W-1:0] exp;
        logic [NORM_W-1:0]           man;
    } norm_t;

endpackage

// File: rtl/man_lzc.sv
// Combinational leading-zero counter over the 27-bit significand+GRS field.
module man_lzc
    import fp_pkg::*;
(
    input  logic [NORM_W-1:0] man,
    output logic [LZC_W-1:0]  count,
    output logic              zero
);

    // Scan LSB to MSB so the highest set bit has the final say.
    always_comb begin
        count = '0;
        zero  = 1'b1;
        for (int unsigned i = 0; i < NORM_W; i++) begin
            if (man[i]) begin
                count = LZC_W'(NORM_W - 1 - i);
                zero  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fp_norm_round.sv
// Two-stage fp32 post-add normalizer (stage 1) and round-to-nearest-even/packer (stage 2).
module fp_norm_round #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_sign,
    input  logic [EXP_W-1:0]              in_exp,
    input  logic [fp_pkg::MAN_SUM_W-1:0]  in_man,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [EXP_W+FRAC_W:0]         out_result
);

    import fp_pkg::norm_t;
    import fp_pkg::NORM_W;
    import fp_pkg::SIG_W;
    import fp_pkg::LZC_W;
    import fp_pkg::EXP_INT_W;
    import fp_pkg::EXP_MAX;
    import fp_pkg::MAN_SUM_W;
    import fp_pkg::GRS_W;

    localparam int unsigned RES_W = EXP_W + FRAC_W + 1;

    logic  v1;
    norm_t s1_d;
    norm_t s1_q;
    logic  s1_adv;
    logic  s2_adv;

    assign s2_adv   = ~out_valid | out_ready;
    assign s1_adv   = ~v1 | s2_adv;
    assign in_ready = s1_adv;

    logic [LZC_W-1:0] lz;
    logic             low_zero;

    man_lzc u_lzc (
        .man   (in_man[NORM_W-1:0]),
        .count (lz),
        .zero  (low_zero)
    );

    // Stage 1: carry right-shift with sticky fold, or left-normalize by leading-zero count.
    always_comb begin
        s1_d.sign = in_sign;
        s1_d.zero = 1'b0;
        s1_d.exp  = EXP_INT_W'(in_exp);
        s1_d.man  = '0;
        if (in_man[MAN_SUM_W-1]) begin
            s1_d.man = {in_man[MAN_SUM_W-1:2], in_man[1] | in_man[0]};
            s1_d.exp = s1_d.exp + EXP_INT_W'(1);
        end else if (low_zero) begin
            s1_d.zero = 1'b1;
        end else begin
            s1_d.man = in_man[NORM_W-1:0] << lz;
            s1_d.exp = s1_d.exp - EXP_INT_W'(lz);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            s1_q <= '0;
        end else if (s1_adv) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    logic                        round_up;
    logic [SIG_W:0]              sig_sum;
    logic [SIG_W-1:0]            frac24;
    logic signed [EXP_INT_W-1:0] exp2;
    logic [RES_W-1:0]            result_d;

    // Stage 2: RNE increment, renormalize on carry-out, then zero/underflow/overflow packing.
    always_comb begin
        round_up = s1_q.man[2] & (s1_q.man[1] | s1_q.man[0] | s1_q.man[3]);
        sig_sum  = {1'b0, s1_q.man[NORM_W-1:GRS_W]} + (SIG_W+1)'(round_up);
        frac24   = sig_sum[SIG_W-1:0];
        exp2     = s1_q.exp;
        if (sig_sum[SIG_W]) begin
            frac24 = {1'b1, {(SIG_W-1){1'b0}}};
            exp2   = exp2 + EXP_INT_W'(1);
        end

        if (s1_q.zero) begin
            result_d = '0;
        end else if (exp2[EXP_INT_W-1] || (exp2 == '0)) begin
            result_d = {s1_q.sign, {(RES_W-1){1'b0}}};
        end else if (exp2 >= EXP_INT_W'(EXP_MAX)) begin
            result_d = {s1_q.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else begin
            result_d = {s1_q.sign, exp2[EXP_W-1:0], frac24[FRAC_W-1:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
        end else if (s2_adv) begin
            out_valid <= v1;
            if (v1) begin
                out_result <= result_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_norm_round.sv
// Self-checking bench for fp_norm_round: vector table through a scoreboard plus stall/reset sequences.
module tb_fp_norm_round;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [27:0] man;
        logic [31:0] res;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int unsigned t;
    } sb_t;

    localparam int NV = 18;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [27:0] in_man;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;

    always #5 clk = ~clk;

    fp_norm_round #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_man     (in_man),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    vec_t        vecs[NV];
    sb_t         sbq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned tick_no = 0;
    int unsigned n_out   = 0;
    bit          check_lat = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, req);
        end
    endtask

    // One cycle: drive at negedge, settle, then account handshakes on both ends.
    task automatic tick(input logic v, input vec_t b, input logic ordy, output logic acc);
        sb_t e;
        @(negedge clk);
        in_valid  = v;
        in_sign   = b.sign;
        in_exp    = b.exp;
        in_man    = b.man;
        out_ready = ordy;
        #1;
        tick_no++;
        acc = v & in_ready;
        if (out_valid && out_ready) begin
            n_out++;
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got %08h with no beat outstanding", out_result);
            end else begin
                e = sbq.pop_front();
                check32("result", out_result, e.res);
                if (check_lat) check32("latency", 32'(tick_no - e.t), 32'd2);
            end
        end
        if (acc) sbq.push_back('{b.res, tick_no});
    endtask

    task automatic send(input vec_t b, input bit random_ready);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 40 && !acc; k++) begin
            tick(1'b1, b, random_ready ? 1'($urandom_range(0, 1)) : 1'b1, acc);
        end
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready got 0, expected 1 within 40 cycles");
        end
    endtask

    task automatic drain();
        logic acc;
        for (int k = 0; k < 50 && sbq.size() != 0; k++) tick(1'b0, '0, 1'b1, acc);
        check32("drain_empty", 32'(sbq.size()), 32'd0);
        sbq.delete();
        for (int k = 0; k < 3; k++) tick(1'b0, '0, 1'b1, acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic [31:0] held;
        int          accepted;
        int unsigned out_before;

        vecs[0]  = '{1'b0, 8'd127, 28'h8000000, 32'h40000000};
        vecs[1]  = '{1'b0, 8'd127, 28'h0000008, 32'h34000000};
        vecs[2]  = '{1'b1, 8'd127, 28'h0000000, 32'h00000000};
        vecs[3]  = '{1'b0, 8'd127, 28'h4000004, 32'h3F800000};
        vecs[4]  = '{1'b0, 8'd127, 28'h400000C, 32'h3F800002};
        vecs[5]  = '{1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000};
        vecs[6]  = '{1'b1, 8'd254, 28'h8000000, 32'hFF800000};
        vecs[7]  = '{1'b0, 8'd3,   28'h0000008, 32'h00000000};
        vecs[8]  = '{1'b0, 8'd127, 28'h8000008, 32'h40000000};
        vecs[9]  = '{1'b0, 8'd127, 28'h8000009, 32'h40000001};
        vecs[10] = '{1'b0, 8'd127, 28'h8000018, 32'h40000002};
        vecs[11] = '{1'b0, 8'd127, 28'h0000001, 32'h32800000};
        vecs[12] = '{1'b0, 8'd1,   28'h4000000, 32'h00800000};
        vecs[13] = '{1'b1, 8'd1,   28'h2000000, 32'h80000000};
        vecs[14] = '{1'b0, 8'd254, 28'h7FFFFFC, 32'h7F800000};
        vecs[15] = '{1'b1, 8'd127, 28'h6000000, 32'hBFC00000};
        vecs[16] = '{1'b0, 8'd127, 28'h4000006, 32'h3F800001};
        vecs[17] = '{1'b1, 8'd127, 28'h2000000, 32'hBF000000};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_man    = '0;
        out_ready = 1'b0;
        #12;
        check32("reset_out_valid", 32'(out_valid), 32'd0);
        check32("reset_out_result", out_result, 32'h0);
        check32("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back stream, no stalls: fixed latency, one result per cycle.
        check_lat = 1'b1;
        for (int i = 0; i < NV; i++) send(vecs[i], 1'b0);
        drain();
        check_lat = 1'b0;

        // Same table under random downstream backpressure.
        for (int i = 0; i < NV; i++) send(vecs[i], 1'b1);
        drain();

        // Hold out_ready low for 3 cycles while offering 4 beats.
        accepted = 0;
        held     = '0;
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, vecs[accepted], 1'b0, acc);
            if (acc) accepted++;
            if (out_valid) held = out_result;
        end
        check32("bp_accepted", 32'(accepted), 32'd2);
        check32("bp_in_ready", 32'(in_ready), 32'd0);
        check32("bp_out_valid", 32'(out_valid), 32'd1);
        out_before = n_out;
        for (int k = 0; k < 4; k++) begin
            if (accepted < 4) begin
                tick(1'b1, vecs[accepted], 1'b1, acc);
                if (acc) accepted++;
            end else begin
                tick(1'b0, '0, 1'b1, acc);
            end
            if (k == 0) check32("bp_held", out_result, held);
        end
        check32("bp_outputs_4_cycles", 32'(n_out - out_before), 32'd4);
        check32("bp_all_accepted", 32'(accepted), 32'd4);
        drain();

        // Fill both stages, then reset asynchronously between clock edges.
        tick(1'b1, vecs[4], 1'b0, acc);
        tick(1'b1, vecs[6], 1'b0, acc);
        tick(1'b0, '0, 1'b0, acc);
        check32("pre_reset_out_valid", 32'(out_valid), 32'd1);
        check32("pre_reset_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check32("async_reset_out_valid", 32'(out_valid), 32'd0);
        check32("async_reset_out_result", out_result, 32'h0);
        check32("async_reset_in_ready", 32'(in_ready), 32'd1);
        sbq.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_lat = 1'b1;
        send(vecs[15], 1'b0);
        drain();
        check_lat = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
